// File: rtl/fifo_rd_pkg.sv
// Shared constants for the FIFO read-side stream controller.
package fifo_rd_pkg;
  localparam int DATA_W_DEF  = 8;
  localparam int BUF_DEPTH   = 2;
  localparam int FRAME_CNT_W = 8;
  localparam int FRAMES_W    = 16;
endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready byte stream with frame delimiter; master drives data, slave drives ready.
interface fifo_stream_reader_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_reader_skid_buf.sv
// Two-entry circular prefetch buffer; head is always presented on dout.
module stream_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        cnt
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              wr_idx;
  logic              rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else if (clear) begin
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_idx] <= din;
        wr_idx      <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rd_idx];

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a registered-output sync FIFO and re-presents bytes as a framed valid/ready stream.
module fifo_stream_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_data,
  output logic                fifo_rd,
  input  logic                flush,
  fifo_stream_reader_if.master strm,
  output logic [FRAMES_W-1:0] frames_sent
);

  localparam logic [FRAME_CNT_W-1:0] LAST_BEAT  = FRAME_CNT_W'(FRAME_LEN - 1);
  localparam logic [FRAMES_W-1:0]    FRAMES_MAX = '1;

  logic                   rd_pending;
  logic                   pop;
  logic                   push;
  logic                   last_beat;
  logic [1:0]             buf_cnt;
  logic [2:0]             occ;
  logic [FRAME_CNT_W-1:0] beat;
  logic [DATA_W-1:0]      head_data;

  assign pop  = strm.m_valid && strm.m_ready;
  // a byte still in flight when flush hits must not land in the cleared buffer
  assign push = rd_pending && !flush;

  // occupancy after this cycle, counting the byte already requested from the FIFO
  assign occ     = {1'b0, buf_cnt} + {2'b0, rd_pending} - {2'b0, pop};
  assign fifo_rd = !reset && !flush && !fifo_empty && (occ < 3'(BUF_DEPTH));

  stream_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_data),
    .dout  (head_data),
    .cnt   (buf_cnt)
  );

  assign last_beat     = (beat == LAST_BEAT);
  assign strm.m_valid  = (buf_cnt != 2'd0);
  assign strm.m_data   = head_data;
  assign strm.m_last   = strm.m_valid && last_beat;

  always_ff @(posedge clk) begin
    if (reset) rd_pending <= 1'b0;
    else       rd_pending <= fifo_rd;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) beat <= '0;
    else if (pop)       beat <= last_beat ? '0 : beat + FRAME_CNT_W'(1);
  end

  // a last beat accepted in the flush cycle still completes its frame
  always_ff @(posedge clk) begin
    if (reset)
      frames_sent <= '0;
    else if (pop && last_beat && (frames_sent != FRAMES_MAX))
      frames_sent <= frames_sent + 16'd1;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: reader paired with a behavioural 8x8 sync FIFO, directed vectors.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        fifo_wr = 1'b0;
  logic [7:0]  fifo_din = 8'h00;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [7:0]  fifo_data = 8'h00;
  logic [15:0] frames_sent;

  fifo_stream_reader_if #(.DATA_W(8)) s_if ();

  fifo_stream_reader #(.DATA_W(8), .FRAME_LEN(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .flush       (flush),
    .strm        (s_if.master),
    .frames_sent (frames_sent)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int acc_cnt = 0;
  int t_rd = -1;
  int t_valid = -1;
  logic lat_arm = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;
  beat_t exp_q[$];

  // 8-entry synchronous FIFO with registered read data
  logic [7:0] fmem [8];
  logic [2:0] wp = 3'd0;
  logic [2:0] rp = 3'd0;
  logic [3:0] fcnt = 4'd0;
  logic       wr_ok;
  logic       rd_ok;

  assign fifo_empty = (fcnt == 4'd0);
  assign wr_ok = fifo_wr && (fcnt != 4'd8);
  assign rd_ok = fifo_rd && (fcnt != 4'd0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      wp        <= 3'd0;
      rp        <= 3'd0;
      fcnt      <= 4'd0;
      fifo_data <= 8'h00;
    end else begin
      if (wr_ok) begin
        fmem[wp] <= fifo_din;
        wp       <= wp + 3'd1;
      end
      if (rd_ok) begin
        fifo_data <= fmem[rp];
        rp        <= rp + 3'd1;
      end
      fcnt <= fcnt + {3'b0, wr_ok} - {3'b0, rd_ok};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: compares every accepted beat against the scoreboard queue
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (fifo_rd) rd_cnt++;
      if (fifo_rd && fifo_empty) begin
        fails++;
        $display("FAIL no_rd_on_empty: fifo_rd=1 while fifo_empty=1 at cycle %0d", cyc);
      end
      if (fifo_wr && fcnt == 4'd8) begin
        fails++;
        $display("FAIL fifo_overflow: write to full FIFO at cycle %0d", cyc);
      end
      if (lat_arm) begin
        if (fifo_rd && t_rd < 0) t_rd = cyc;
        if (s_if.m_valid && t_valid < 0) t_valid = cyc;
      end
      if (s_if.m_valid && s_if.m_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL beat_unexpected: got data 0x%0h last %0b, expected no beat", s_if.m_data, s_if.m_last);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(s_if.m_data), 32'(e.data));
          check("beat_last", 32'(s_if.m_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    fifo_din = d;
    fifo_wr  = 1'b1;
    tick();
    fifo_wr  = 1'b0;
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    beat_t e;
    e.data = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || s_if.m_valid) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    int acc0;
    int rd0;
    s_if.m_ready = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_m_valid", 32'(s_if.m_valid), 32'h0);
    check("rst_m_data", 32'(s_if.m_data), 32'h0);
    check("rst_m_last", 32'(s_if.m_last), 32'h0);
    check("rst_frames", 32'(frames_sent), 32'h0);
    check("rst_fifo_rd", 32'(fifo_rd), 32'h0);
    reset = 1'b0;
    tick();

    // 1: single frame, latency from first pop to first valid
    s_if.m_ready = 1'b1;
    lat_arm = 1'b1;
    expect_beat(8'h11, 1'b0);
    expect_beat(8'h12, 1'b0);
    expect_beat(8'h13, 1'b0);
    expect_beat(8'h14, 1'b1);
    wr(8'h11); wr(8'h12); wr(8'h13); wr(8'h14);
    drain();
    lat_arm = 1'b0;
    check("t1_rd_seen", 32'(t_rd >= 0), 32'h1);
    check("t1_latency", 32'(t_valid - t_rd), 32'd2);
    check("t1_frames", 32'(frames_sent), 32'd1);

    // 2: backpressure holds first byte, prefetch stops at two
    s_if.m_ready = 1'b0;
    rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) expect_beat(8'h21 + 8'(i), (i == 3 || i == 7));
    for (int i = 0; i < 8; i++) wr(8'h21 + 8'(i));
    repeat (10) tick();
    check("t2_rd_pulses", 32'(rd_cnt - rd0), 32'd2);
    check("t2_valid_held", 32'(s_if.m_valid), 32'h1);
    check("t2_data_held", 32'(s_if.m_data), 32'h21);
    s_if.m_ready = 1'b1;
    acc0 = acc_cnt;
    repeat (8) tick();
    check("t2_back_to_back", 32'(acc_cnt - acc0), 32'd8);
    drain();
    check("t2_frames", 32'(frames_sent), 32'd3);

    // 3: alternating ready, three frames
    for (int i = 0; i < 12; i++) expect_beat(8'h31 + 8'(i), (i == 3 || i == 7 || i == 11));
    fork
      begin
        for (int i = 0; i < 12; i++) wr(8'h31 + 8'(i));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          s_if.m_ready = (k % 2 == 0);
          tick();
        end
      end
    join
    s_if.m_ready = 1'b1;
    drain();
    check("t3_frames", 32'(frames_sent), 32'd6);

    // 4: flush while a byte is in flight and the buffer is refilling
    s_if.m_ready = 1'b0;
    expect_beat(8'h41, 1'b0);
    wr(8'h41); wr(8'h42); wr(8'h43); wr(8'h44);
    repeat (6) tick();
    s_if.m_ready = 1'b1;
    @(negedge clk);
    check("t4_rd_with_pop", 32'(fifo_rd), 32'h1);
    tick();
    s_if.m_ready = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("t4_no_rd_in_flush", 32'(fifo_rd), 32'h0);
    tick();
    flush = 1'b0;
    check("t4_valid_after_flush", 32'(s_if.m_valid), 32'h0);
    expect_beat(8'h44, 1'b0);
    expect_beat(8'h45, 1'b0);
    expect_beat(8'h46, 1'b0);
    expect_beat(8'h47, 1'b1);
    s_if.m_ready = 1'b1;
    wr(8'h45); wr(8'h46); wr(8'h47);
    drain();
    check("t4_frames", 32'(frames_sent), 32'd7);

    // 5: FIFO runs dry mid-frame, frame resumes later
    expect_beat(8'h51, 1'b0);
    expect_beat(8'h52, 1'b0);
    wr(8'h51); wr(8'h52);
    drain();
    repeat (20) tick();
    check("t5_idle_valid", 32'(s_if.m_valid), 32'h0);
    check("t5_idle_frames", 32'(frames_sent), 32'd7);
    expect_beat(8'h53, 1'b0);
    expect_beat(8'h54, 1'b1);
    wr(8'h53); wr(8'h54);
    drain();
    check("t5_frames", 32'(frames_sent), 32'd8);

    // 6: reset with a full buffer
    s_if.m_ready = 1'b0;
    wr(8'h61); wr(8'h62); wr(8'h63);
    repeat (6) tick();
    check("t6_pre_valid", 32'(s_if.m_valid), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rd_in_reset", 32'(fifo_rd), 32'h0);
    tick();
    check("t6_m_valid", 32'(s_if.m_valid), 32'h0);
    check("t6_m_data", 32'(s_if.m_data), 32'h0);
    check("t6_m_last", 32'(s_if.m_last), 32'h0);
    check("t6_frames", 32'(frames_sent), 32'h0);
    reset = 1'b0;
    tick();
    s_if.m_ready = 1'b1;
    expect_beat(8'h71, 1'b0);
    expect_beat(8'h72, 1'b0);
    expect_beat(8'h73, 1'b0);
    expect_beat(8'h74, 1'b1);
    wr(8'h71); wr(8'h72); wr(8'h73); wr(8'h74);
    drain();
    check("t6_post_frames", 32'(frames_sent), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
